lag_xbar_allocator: RTL and testbench
=====================================

LAG_XBAR_ALLOCATOR -- requirements
Module: LAG_xbar_allocator

Interface
REQ-001 Parameter np, default 5: number of router ports.
REQ-002 Parameter max_links_num, default 2: links per port; N = np*max_links_num is the flat link count for inputs and outputs.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req  input  [N-1:0][N-1:0]  req[i][o]=1: input link i requests output link o; at most one o per i.
REQ-006 req_tail  input  [N-1:0]  flit at input i is the packet tail (single-flit packet = head+tail).
REQ-007 out_ready  input  [N-1:0]  output link o can accept a flit this cycle.
REQ-008 select  output  [N-1:0][N-1:0]  select[o][i]: one-hot crossbar select per output o, in the format the crossbar consumes.
REQ-009 grant  output  [N-1:0]  input i's flit is transferred this cycle.

Function
REQ-010 Grant is combinational from req, req_tail, out_ready and registered state; zero-cycle latency request-to-grant.
REQ-011 Each output o has state: rr_ptr[o] (0..N-1), lock[o] (FREE/LOCKED), owner[o] (0..N-1).
REQ-012 Output o with out_ready[o]=0 grants nothing; its state holds.
REQ-013 FREE output, out_ready=1: grant the first requesting input searching i = rr_ptr, rr_ptr+1, ... mod N (wrap at N-1 to 0).
REQ-014 LOCKED output, out_ready=1: grant only owner[o], and only if req[owner][o]=1; other requests are ignored.
REQ-015 select[o] is all-zero or exactly one-hot; grant[i] = OR over o of select[o][i]; no input granted to two outputs.
REQ-016 FREE output grant with req_tail=0: next state LOCKED, owner = granted input.
REQ-017 Grant with req_tail=1 (FREE or LOCKED): next state FREE; rr_ptr = (granted+1) mod N.
REQ-018 LOCKED grant with req_tail=0: state, owner and rr_ptr unchanged.
REQ-019 rr_ptr changes only on a tail grant; a non-tail FREE grant leaves it unchanged.
REQ-020 A tail grant and a new head from another input in the same cycle: the head waits; the output is arbitrated FREE next cycle from the updated rr_ptr.
REQ-021 Owner drops its request while LOCKED: no grant; lock held indefinitely until the owner's tail is granted.
REQ-022 Requests to different outputs are arbitrated independently in the same cycle.
REQ-023 req[i][o] with o outside an existing link or more than one bit set per row is illegal; behaviour unspecified, flagged by bench assertion.

Reset
REQ-024 While rst=1: rr_ptr=0, lock=FREE, owner=0 for all outputs; select and grant forced to all-zero regardless of inputs.
REQ-025 Reset asserted mid-packet discards all locks; after release, arbitration restarts FREE from input 0.
REQ-026 First grant possible in the first cycle with rst=0.

Configuration
REQ-027 Macro LAG_XBAR_ALLOC_PKT_LOCK_EN defined: packet locking per REQ-014/016/018/021.
REQ-028 Macro not defined: no lock state; every flit is treated as a tail for arbitration (each grant advances rr_ptr to granted+1); req_tail is ignored; lock/owner logic absent from the netlist.

Verification
REQ-029 N=10, inputs 2 and 7 request output 4 with req_tail=1, rr_ptr[4]=0 -> input 2 granted, select[4]=bit 2; next cycle input 7 granted; rr_ptr[4]=8.
REQ-030 Input 3 sends 4-flit packet to output 0 (tail on flit 4), input 5 requests output 0 throughout -> input 3 granted 4 consecutive cycles, input 5 granted cycle 5 (lock macro on); lock macro off -> grants alternate 3,5,3,5.
REQ-031 Output 6 LOCKED to input 1, out_ready[6]=0 for 3 cycles -> no grant, lock held; out_ready=1 -> input 1 granted, no other input granted.
REQ-032 rr_ptr[9]=9, inputs 0 and 9 request output 9 with tail -> input 9 granted, rr_ptr wraps to 0; next grant input 0.
REQ-033 rst asserted while output 2 LOCKED mid-packet -> select/grant zero immediately (asynchronously); after release, head from input 8 granted output 2 without waiting for the old owner.

Source files
------------

// File: rtl/lag_xbar_allocator.sv
// rtl/lag_xbar_allocator.sv - per-output round-robin crossbar allocator with optional packet locking
// Optional feature: define LAG_XBAR_ALLOC_PKT_LOCK_EN to hold an output for a whole packet.
module lag_xbar_allocator #(
   parameter int np            = 5,
   parameter int max_links_num = 2,
   localparam int N            = np * max_links_num,
   localparam int W            = (N > 1) ? $clog2(N) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N-1:0][N-1:0]   req,
   input  logic [N-1:0]          req_tail,
   input  logic [N-1:0]          out_ready,
   output logic [N-1:0][N-1:0]   select,
   output logic [N-1:0]          grant
);

   logic [N-1:0][W-1:0] rr_ptr;
   logic [N-1:0][W-1:0] gidx;
   logic [N-1:0]        gvalid;

`ifdef LAG_XBAR_ALLOC_PKT_LOCK_EN
   logic [N-1:0]        lock;
   logic [N-1:0][W-1:0] owner;
`else
   logic                unused_tail;
   assign unused_tail = ^req_tail;
`endif

   // Per-output arbitration: locked outputs serve only their owner, free outputs search from rr_ptr
   always_comb begin
      int  idx;
      logic found;
      select = '0;
      gidx   = '0;
      gvalid = '0;
      idx    = 0;
      found  = 1'b0;
      for (int o = 0; o < N; o++) begin
         found = 1'b0;
         if (out_ready[o] && !rst) begin
`ifdef LAG_XBAR_ALLOC_PKT_LOCK_EN
            if (lock[o]) begin
               if (req[owner[o]][o]) begin
                  select[o][owner[o]] = 1'b1;
                  gidx[o]             = owner[o];
                  gvalid[o]           = 1'b1;
               end
               found = 1'b1;
            end
`endif
            for (int k = 0; k < N; k++) begin
               idx = int'(rr_ptr[o]) + k;
               if (idx >= N) idx = idx - N;
               if (!found && req[idx][o]) begin
                  select[o][idx] = 1'b1;
                  gidx[o]        = W'(idx);
                  gvalid[o]      = 1'b1;
                  found          = 1'b1;
               end
            end
         end
      end
   end

   // An input is granted when any output selects it
   always_comb begin
      grant = '0;
      for (int o = 0; o < N; o++) begin
         grant = grant | select[o];
      end
   end

   // Arbitration state update; tail grants free the output and move the pointer past the winner
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr <= '0;
`ifdef LAG_XBAR_ALLOC_PKT_LOCK_EN
         lock   <= '0;
         owner  <= '0;
`endif
      end else begin
         for (int o = 0; o < N; o++) begin
            if (gvalid[o]) begin
`ifdef LAG_XBAR_ALLOC_PKT_LOCK_EN
               if (req_tail[gidx[o]]) begin
                  lock[o]   <= 1'b0;
                  rr_ptr[o] <= (gidx[o] == W'(N-1)) ? '0 : gidx[o] + 1'b1;
               end else if (!lock[o]) begin
                  lock[o]  <= 1'b1;
                  owner[o] <= gidx[o];
               end
`else
               rr_ptr[o] <= (gidx[o] == W'(N-1)) ? '0 : gidx[o] + 1'b1;
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_lag_xbar_allocator.sv
// tb/tb_lag_xbar_allocator.sv - directed self-checking bench for lag_xbar_allocator
module tb_lag_xbar_allocator;

   localparam int NP = 5;
   localparam int ML = 2;
   localparam int N  = NP * ML;

   logic                clk = 1'b0;
   logic                rst;
   logic [N-1:0][N-1:0] req;
   logic [N-1:0]        req_tail;
   logic [N-1:0]        out_ready;
   logic [N-1:0][N-1:0] select;
   logic [N-1:0]        grant;

   int total = 0;
   int bad   = 0;

   lag_xbar_allocator #(.np(NP), .max_links_num(ML)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .req_tail  (req_tail),
      .out_ready (out_ready),
      .select    (select),
      .grant     (grant)
   );

   // 10 time-unit clock
   always #5 clk = ~clk;

   // Stimulus legality: each input requests at most one output
   always @(negedge clk) begin
      for (int i = 0; i < N; i++) begin
         assert ($onehot0(req[i])) else $error("FAIL illegal_req row=%0d value=%0h required=onehot0", i, req[i]);
      end
   end

   function automatic logic [N-1:0] oh(input int i);
      logic [N-1:0] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clr();
      req       = '0;
      req_tail  = '0;
      out_ready = '1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int exp_seq [4];
      logic [N-1:0] e;
`ifdef LAG_XBAR_ALLOC_PKT_LOCK_EN
      exp_seq = '{3, 3, 3, 3};
`else
      exp_seq = '{3, 5, 3, 5};
`endif

      // Reset holds outputs at zero even with requests present
      rst = 1'b1;
      clr();
      req[2][4] = 1'b1;
      req[7][1] = 1'b1;
      tick();
      tick();
      chk("reset_grant", grant, '0);
      chk("reset_select", select, '0);

      // Two inputs to output 4 with tail; first cycle out of reset grants
      rst = 1'b0;
      clr();
      req[2][4] = 1'b1; req[7][4] = 1'b1;
      req_tail = '1;
      #3;
      chk("rr_c1_grant", grant, oh(2));
      chk("rr_c1_sel4", select[4], oh(2));
      tick();
      #3;
      chk("rr_c2_grant", grant, oh(7));
      chk("rr_c2_sel4", select[4], oh(7));
      tick();
      clr();
      req_tail = '1;
      req[1][4] = 1'b1; req[9][4] = 1'b1;
      #3;
      chk("rr_ptr8_grant", grant, oh(9));
      tick();

      // Independent outputs in one cycle
      clr();
      req_tail = '1;
      req[0][1] = 1'b1; req[3][1] = 1'b1; req[5][2] = 1'b1; req[6][9] = 1'b1;
      #3;
      chk("indep_grant", grant, oh(0) | oh(5) | oh(6));
      chk("indep_sel1", select[1], oh(0));
      chk("indep_sel2", select[2], oh(5));
      chk("indep_sel9", select[9], oh(6));
      tick();

      // Drive rr_ptr[9] to 9, then wrap
      clr();
      req_tail = '1;
      req[8][9] = 1'b1;
      #3;
      chk("wrap_setup_grant", grant, oh(8));
      tick();
      clr();
      req_tail = '1;
      req[0][9] = 1'b1; req[9][9] = 1'b1;
      #3;
      chk("wrap_c1_sel9", select[9], oh(9));
      tick();
      #3;
      chk("wrap_c2_sel9", select[9], oh(0));
      tick();

      // Not-ready output grants nothing while another output proceeds
      clr();
      req_tail = '1;
      out_ready[3] = 1'b0;
      req[4][3] = 1'b1; req[1][5] = 1'b1;
      #3;
      chk("notready_grant", grant, oh(1));
      chk("notready_sel3", select[3], '0);
      tick();
      out_ready[3] = 1'b1;
      req[1][5] = 1'b0;
      #3;
      chk("ready_again_grant", grant, oh(4));
      tick();

      // Four-flit packet from input 3 competing with input 5 on output 0
      for (int c = 0; c < 4; c++) begin
         clr();
         req[3][0] = 1'b1; req[5][0] = 1'b1;
         req_tail[5] = 1'b1;
         req_tail[3] = (c == 3);
         #3;
         chk($sformatf("pkt_flit%0d_sel0", c), select[0], oh(exp_seq[c]));
         tick();
      end
      clr();
      req[5][0] = 1'b1; req_tail[5] = 1'b1;
      #3;
      chk("pkt_after_sel0", select[0], oh(5));
      tick();

      // Output 6: head from input 1, then stall with competition, then release
      clr();
      req[1][6] = 1'b1;
      #3;
      chk("stall_head_grant", grant, oh(1));
      tick();
      for (int c = 0; c < 3; c++) begin
         clr();
         out_ready[6] = 1'b0;
         req[1][6] = 1'b1; req[2][6] = 1'b1; req_tail[2] = 1'b1;
         #3;
         chk($sformatf("stall_c%0d_grant", c), grant, '0);
         tick();
      end
      out_ready[6] = 1'b1;
`ifdef LAG_XBAR_ALLOC_PKT_LOCK_EN
      e = oh(1);
`else
      e = oh(2);
`endif
      #3;
      chk("stall_release_grant", grant, e);
      tick();
      clr();
      req[2][6] = 1'b1; req_tail[2] = 1'b1;
`ifdef LAG_XBAR_ALLOC_PKT_LOCK_EN
      e = '0;
`else
      e = oh(2);
`endif
      #3;
      chk("owner_dropped_grant", grant, e);
      tick();

      // Output 2 mid-packet, then asynchronous reset
      clr();
      req[0][2] = 1'b1;
      #3;
      chk("mid_pkt_head_grant", grant, oh(0));
      tick();
      clr();
      req[0][2] = 1'b1; req[8][2] = 1'b1;
`ifdef LAG_XBAR_ALLOC_PKT_LOCK_EN
      e = oh(0);
`else
      e = oh(8);
`endif
      #2;
      chk("mid_pkt_body_grant", grant, e);
      rst = 1'b1;
      #1;
      chk("async_rst_grant", grant, '0);
      chk("async_rst_select", select, '0);
      tick();
      rst = 1'b0;
      clr();
      req[8][2] = 1'b1;
      req[0][9] = 1'b1; req[5][9] = 1'b1; req_tail[0] = 1'b1; req_tail[5] = 1'b1;
      #3;
      chk("post_rst_grant", grant, oh(8) | oh(0));
      chk("post_rst_sel2", select[2], oh(8));
      chk("post_rst_sel9", select[9], oh(0));
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
